result_uart_tx: RTL and testbench

Transmit-side framer for the sparse matrix coprocessor's serial link. It accepts 16-bit FPU results and their status flags over a valid/ready handshake, and buffers them in a small FIFO. It serialises each result as a 5-byte checksummed frame onto `TxD` (UART 8N1, LSB first). This block is the device-to-host counterpart of the command receive path in `comm`, and sits between the FPU result port and the `TxD` pin.

---
 rtl/sm_comm_pkg.sv | 45 ++++
 rtl/result_uart_tx_if.sv | 25 ++
 rtl/uart_tx_byte.sv | 67 ++++++
 rtl/result_uart_tx.sv | 121 ++++++++++++
 tb/tb_result_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_comm_pkg.sv
// Shared types and constants for the coprocessor serial link.
// Frame layout helper used by the result transmit framer.
package sm_comm_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_LOAD,
    FR_SEND
  } fr_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
    logic nan;
  } fpu_flags_t;

  typedef struct packed {
    fpu_flags_t  flags;
    logic [15:0] data;
  } res_entry_t;

  // Bytes packed LSB-first so the framer can shift them out.
  function automatic logic [39:0] build_frame(
    input logic [3:0] seq,
    input res_entry_t e
  );
    logic [7:0] b1, b2, b3;
    b1 = e.data[15:8];
    b2 = e.data[7:0];
    b3 = {seq, e.flags};
    return {b1 ^ b2 ^ b3, b3, b2, b1, SYNC_BYTE};
  endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// FPU result handshake into the serial transmit framer.
// The producer side is master, the framer is slave.
interface result_uart_tx_if;
  import sm_comm_pkg::*;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  fpu_flags_t  res_flags;

  modport master (
    output res_valid,
    output res_data,
    output res_flags,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_flags,
    output res_ready
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a flopped line output.
// Ready rises in the last stop-bit clock so bytes run back-to-back.
module uart_tx_byte
  import sm_comm_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd
);

  localparam int CW = $clog2(DIV);

  ser_state_t    st_q, st_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [9:0]    sr_q;
  logic          bit_end;
  logic          take;

  assign bit_end = baud_q == CW'(DIV - 1);
  assign byte_ready = (st_q == SER_IDLE)
                    | ((st_q == SER_STOP) & bit_end);
  assign take = byte_valid & byte_ready;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      SER_IDLE:  if (take) st_d = SER_START;
      SER_START: if (bit_end) st_d = SER_DATA;
      SER_DATA:  if (bit_end && bit_q == 3'd7) st_d = SER_STOP;
      SER_STOP:  if (bit_end) st_d = take ? SER_START : SER_IDLE;
      default:   st_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= SER_IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sr_q   <= '1;
      txd    <= 1'b1;
    end else begin
      st_q <= st_d;
      if (take) begin
        baud_q <= '0;
        bit_q  <= '0;
        sr_q   <= {1'b1, byte_data, 1'b0};
        txd    <= 1'b0;
      end else if (st_q != SER_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          // sr_q[1] is the bit that follows the one now on the line
          sr_q <= {1'b1, sr_q[9:1]};
          txd  <= sr_q[1];
          if (st_q == SER_DATA) bit_q <= bit_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Result FIFO plus framer: sends each FPU result as a 5-byte
// checksummed frame over the TxD line.
module result_uart_tx
  import sm_comm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  result_uart_tx_if.slave res,
  output logic            TxD,
  output logic            TxD_busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  res_entry_t    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q;
  logic          push, pop, empty;

  fr_state_t     fs_q, fs_d;
  res_entry_t    ent_q;
  logic [39:0]   frm_q;
  logic [2:0]    idx_q;
  logic [3:0]    seq_q;
  logic          byte_valid, byte_ready, take;

  assign empty = cnt_q == '0;
  assign push  = res.res_valid & ready_q;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign res.res_ready = ready_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {res.res_flags, res.res_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      ready_q <= cnt_d != FULL;
    end
  end

  assign take = byte_valid & byte_ready;

  always_comb begin
    fs_d       = fs_q;
    pop        = 1'b0;
    byte_valid = 1'b0;
    unique case (fs_q)
      FR_IDLE: begin
        if (!empty) begin
          pop  = 1'b1;
          fs_d = FR_LOAD;
        end
      end
      FR_LOAD: fs_d = FR_SEND;
      FR_SEND: begin
        byte_valid = idx_q != 3'(FRAME_BYTES);
        // All bytes handed over and B4 is in its last stop clock
        if (!byte_valid && byte_ready) begin
          if (!empty) begin
            pop  = 1'b1;
            fs_d = FR_LOAD;
          end else begin
            fs_d = FR_IDLE;
          end
        end
      end
      default: fs_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_q  <= FR_IDLE;
      ent_q <= '0;
      frm_q <= '0;
      idx_q <= '0;
      seq_q <= '0;
    end else begin
      fs_q <= fs_d;
      if (pop) ent_q <= mem_q[rd_q];
      if (fs_q == FR_LOAD) begin
        frm_q <= build_frame(seq_q, ent_q);
        seq_q <= seq_q + 1'b1;
        idx_q <= '0;
      end else if (take) begin
        frm_q <= {8'h00, frm_q[39:8]};
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign TxD_busy = !empty | (fs_q != FR_IDLE);

  uart_tx_byte #(
    .DIV (DIV)
  ) u_ser (
    .clk        (clk),
    .rst_n      (reset),
    .byte_valid (byte_valid),
    .byte_data  (frm_q[7:0]),
    .byte_ready (byte_ready),
    .txd        (TxD)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at 4 clocks per bit.
// A line monitor decodes TxD bytes, start cycles and idle gaps.
module tb_result_uart_tx;
  import sm_comm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, busy;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int stop_err = 0;
  int last_push = 0;

  logic [7:0] rx_q[$];
  int st_q[$];
  int gap_q[$];

  result_uart_tx_if rif();

  result_uart_tx #(
    .CLK_HZ     (4),
    .BAUD       (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .res      (rif),
    .TxD      (txd),
    .TxD_busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Line monitor: offset 0 is the first low sample of a start bit
  initial begin : mon
    int off;
    int hi;
    bit act;
    logic [7:0] b;
    off = 0;
    hi = 0;
    act = 1'b0;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
        hi = 0;
      end else if (!act) begin
        if (txd === 1'b0) begin
          act = 1'b1;
          off = 1;
          st_q.push_back(cyc);
          gap_q.push_back(hi);
          hi = 0;
        end else begin
          hi++;
        end
      end else begin
        if (off >= 6 && off <= 34 && off % 4 == 2)
          b[(off - 6) / 4] = txd;
        if (off == 38 && txd !== 1'b1) stop_err++;
        if (off == 39) begin
          act = 1'b0;
          rx_q.push_back(b);
        end
        off++;
      end
    end
  end

  function automatic logic [39:0] exp_frame(
    input logic [15:0] d,
    input logic [3:0] f,
    input logic [3:0] s
  );
    logic [7:0] b3;
    b3 = {s, f};
    return {8'hA5, d[15:8], d[7:0], b3, d[15:8] ^ d[7:0] ^ b3};
  endfunction

  function automatic logic [39:0] frame_of(input int k);
    return {rx_q[5*k], rx_q[5*k+1], rx_q[5*k+2],
            rx_q[5*k+3], rx_q[5*k+4]};
  endfunction

  task automatic clr();
    rx_q.delete();
    st_q.delete();
    gap_q.delete();
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] f);
    int t;
    t = 0;
    @(negedge clk);
    while (rif.res_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("push_tmo", 64'(t), 64'(0));
    rif.res_valid = 1'b1;
    rif.res_data  = d;
    rif.res_flags = fpu_flags_t'(f);
    @(posedge clk);
    #1;
    last_push = cyc;
    rif.res_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p;
    int nb;
    bit quiet;
    logic [15:0] wd[17];
    logic [3:0] wf[17];

    rif.res_valid = 1'b0;
    rif.res_data  = '0;
    rif.res_flags = fpu_flags_t'(4'h0);

    // reset state and quiet line
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 64'(txd), 64'(1));
    chk("rst_rdy", 64'(rif.res_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("quiet_line", 64'(quiet), 64'(1));
    chk("quiet_starts", 64'(st_q.size()), 64'(0));

    // single push
    clr();
    push(16'h3C00, 4'b0010);
    p = last_push;
    wait_cyc(p + 1);
    chk("s_busy_rise", 64'(busy), 64'(1));
    wait_cyc(p + 202);
    chk("s_busy_202", 64'(busy), 64'(1));
    wait_cyc(p + 203);
    chk("s_busy_203", 64'(busy), 64'(0));
    wait_bytes("s_tmo", 5, 50);
    chk("s_frame", 64'(frame_of(0)), 64'(40'hA53C00023E));
    chk("s_lat", 64'(st_q[0] - p), 64'(3));
    chk("s_rdy", 64'(rif.res_ready), 64'(1));

    // burst of 12
    do_reset();
    clr();
    for (int k = 1; k <= 12; k++) begin
      push(16'(k), 4'(k));
      if (k == 8) chk("b_rdy8", 64'(rif.res_ready), 64'(1));
      if (k == 9) chk("b_rdy9", 64'(rif.res_ready), 64'(0));
    end
    wait_bytes("b_tmo", 60, 3000);
    for (int i = 0; i < 12; i++)
      chk($sformatf("b_frame%0d", i), 64'(frame_of(i)),
          64'(exp_frame(16'(i + 1), 4'(i + 1), 4'(i))));
    nb = 0;
    for (int i = 1; i < 12; i++) begin
      if (gap_q[5*i] != 2) nb++;
      if (st_q[5*i] - st_q[5*i-5] != 202) nb++;
    end
    chk("b_gaps", 64'(nb), 64'(0));
    nb = 0;
    for (int i = 0; i < 60; i++)
      if (i % 5 != 0 && gap_q[i] != 0) nb++;
    chk("b_b2b", 64'(nb), 64'(0));
    wait_idle("b_idle", 400);

    // sequence wrap
    do_reset();
    clr();
    for (int i = 0; i < 17; i++) begin
      wd[i] = 16'h1000 + 16'(i * 16'h0111);
      wf[i] = 4'(15 - i);
      push(wd[i], wf[i]);
      wait_idle($sformatf("w_idle%0d", i), 400);
    end
    wait_bytes("w_tmo", 85, 50);
    for (int i = 0; i < 17; i++)
      chk($sformatf("w_frame%0d", i), 64'(frame_of(i)),
          64'(exp_frame(wd[i], wf[i], 4'(i % 16))));
    chk("w_seq16", 64'(rx_q[83][7:4]), 64'(0));

    // reset in the middle of B2
    clr();
    push(16'h1111, 4'h3);
    wait_bytes("r_tmo", 2, 300);
    repeat (10) @(posedge clk);
    #1;
    chk("r_pre", 64'(txd), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("r_txd", 64'(txd), 64'(1));
    chk("r_rdy", 64'(rif.res_ready), 64'(1));
    chk("r_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("r_quiet", 64'(busy), 64'(0));
    clr();
    push(16'hBEEF, 4'b1001);
    p = last_push;
    wait_bytes("r2_tmo", 5, 400);
    chk("r_frame", 64'(frame_of(0)), 64'(40'hA5BEEF0958));
    chk("r_lat", 64'(st_q[0] - p), 64'(3));
    repeat (20) @(posedge clk);
    #1;
    chk("r_nbytes", 64'(rx_q.size()), 64'(5));

    // push lands on the edge starting B4's last stop clock
    clr();
    push(16'h0F0F, 4'h4);
    p = last_push;
    wait_cyc(p + 201);
    push(16'h7E81, 4'h8);
    wait_bytes("l_tmo", 10, 600);
    chk("l_frame0", 64'(frame_of(0)), 64'(40'hA50F0F1414));
    chk("l_frame1", 64'(frame_of(1)), 64'(40'hA57E8128D7));
    chk("l_gap", 64'(gap_q[5]), 64'(2));
    chk("l_space", 64'(st_q[5] - st_q[0]), 64'(202));
    wait_idle("l_idle", 400);

    chk("stop_bits", 64'(stop_err), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
